// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared FSM state type and width helpers for the shift-add multiplier
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/shift_add_mult_seq_step.sv
// rtl/shift_add_mult_seq_step.sv - one combinational shift-and-add iteration
module shift_add_step
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [prod_w(WIDTH)-1:0] acc,
  input  logic [prod_w(WIDTH)-1:0] m_s,
  input  logic [WIDTH-1:0]         q_s,
  output logic [prod_w(WIDTH)-1:0] acc_nxt,
  output logic [prod_w(WIDTH)-1:0] m_s_nxt,
  output logic [WIDTH-1:0]         q_s_nxt
);

  always_comb begin
    acc_nxt = q_s[0] ? (acc + m_s) : acc;
    m_s_nxt = m_s << 1;
    q_s_nxt = q_s >> 1;
  end

endmodule

// File: rtl/shift_add_mult_seq.sv
// rtl/shift_add_mult_seq.sv - sequential WIDTH x WIDTH shift-add multiplier, signed mode via SHIFT_ADD_SIGNED_EN
module shift_add_mult_seq
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         m,
  input  logic [WIDTH-1:0]         q,
`ifdef SHIFT_ADD_SIGNED_EN
  input  logic                     sgn,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [prod_w(WIDTH)-1:0] p
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = prod_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    m_s;
  logic [WIDTH-1:0] q_s;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    m_s_nxt;
  logic [WIDTH-1:0] q_s_nxt;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] m_mag;
  logic [WIDTH-1:0] q_mag;
  logic             neg_in;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

`ifdef SHIFT_ADD_SIGNED_EN
  // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is the right unsigned magnitude.
  always_comb begin
    m_mag  = (sgn && m[WIDTH-1]) ? -m : m;
    q_mag  = (sgn && q[WIDTH-1]) ? -q : q;
    neg_in = sgn && (m[WIDTH-1] ^ q[WIDTH-1]);
  end
`else
  always_comb begin
    m_mag  = m;
    q_mag  = q;
    neg_in = 1'b0;
  end
`endif

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc    (acc),
    .m_s    (m_s),
    .q_s    (q_s),
    .acc_nxt(acc_nxt),
    .m_s_nxt(m_s_nxt),
    .q_s_nxt(q_s_nxt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
      m_s <= '0;
      q_s <= '0;
      cnt <= '0;
      neg <= 1'b0;
      p   <= '0;
    end else if (accept) begin
      acc <= '0;
      m_s <= {{WIDTH{1'b0}}, m_mag};
      q_s <= q_mag;
      cnt <= '0;
      neg <= neg_in;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      m_s <= m_s_nxt;
      q_s <= q_s_nxt;
      cnt <= cnt + CNT_W'(1);
      // p only moves on the final iteration so it holds the last product throughout a run.
      if (last) begin
        p <= neg ? -acc_nxt : acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// tb/tb_shift_add_mult_seq.sv - directed self-checking bench for shift_add_mult_seq (WIDTH 4 and 8)
module tb_shift_add_mult_seq;

  logic        clk;
  logic        n_rst4, n_rst8;
  logic        start4, start8;
  logic [3:0]  m4, q4;
  logic [7:0]  m8, q8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;
`ifdef SHIFT_ADD_SIGNED_EN
  logic        sgn4, sgn8;
`endif

  int n_vec;
  int n_err;

  shift_add_mult_seq #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .n_rst(n_rst4),
    .start(start4),
    .m    (m4),
    .q    (q4),
`ifdef SHIFT_ADD_SIGNED_EN
    .sgn  (sgn4),
`endif
    .busy (busy4),
    .done (done4),
    .p    (p4)
  );

  shift_add_mult_seq #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .n_rst(n_rst8),
    .start(start8),
    .m    (m8),
    .q    (q8),
`ifdef SHIFT_ADD_SIGNED_EN
    .sgn  (sgn8),
`endif
    .busy (busy8),
    .done (done8),
    .p    (p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one 4-bit product, check done timing over the 4 RUN edges, then the product.
  task automatic run4(input logic [3:0] mm, input logic [3:0] qq, input logic [7:0] exp, input string tag);
    m4 = mm;
    q4 = qq;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk({tag, "_done"}, 64'(done4), 64'(k == 4));
    end
    chk({tag, "_p"}, 64'(p4), 64'(exp));
  endtask

  task automatic run8(input logic [7:0] mm, input logic [7:0] qq, input logic [15:0] exp, input string tag);
    m8 = mm;
    q8 = qq;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, "_done"}, 64'(done8), 64'(k == 8));
    end
    chk({tag, "_p"}, 64'(p8), 64'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_rst4 = 1'b0;
    n_rst8 = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    m4 = '0; q4 = '0; m8 = '0; q8 = '0;
`ifdef SHIFT_ADD_SIGNED_EN
    sgn4 = 1'b0;
    sgn8 = 1'b0;
`endif
    #1;
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_done4", 64'(done4), 64'd0);
    chk("rst_p4", 64'(p4), 64'd0);
    chk("rst_p8", 64'(p8), 64'd0);
    tick();
    tick();
    n_rst4 = 1'b1;
    n_rst8 = 1'b1;
    tick();

    // 15 x 15 on WIDTH=4: busy for 4 cycles, done one cycle after E4.
    m4 = 4'd15;
    q4 = 4'd15;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("max_busy", 64'(busy4), 64'd1);
      chk("max_nodone", 64'(done4), 64'd0);
      tick();
    end
    chk("max_busy_last", 64'(busy4), 64'd1);
    chk("max_p_before", 64'(p4), 64'd0);
    tick();
    chk("max_done", 64'(done4), 64'd1);
    chk("max_busy_off", 64'(busy4), 64'd0);
    chk("max_p", 64'(p4), 64'hE1);
    tick();
    chk("max_done_drop", 64'(done4), 64'd0);
    chk("max_p_hold", 64'(p4), 64'hE1);
    tick();
    chk("max_p_hold2", 64'(p4), 64'hE1);

    // WIDTH=8 directed products.
    run8(8'h00, 8'hAB, 16'h0000, "w8_zero");
    tick();
    run8(8'hFF, 8'hFF, 16'hFE01, "w8_max");
    tick();
    run8(8'h12, 8'h34, 16'h03A8, "w8_mid");
    tick();

    // start during RUN must be ignored.
    m4 = 4'd3;
    q4 = 4'd5;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    m4 = 4'd15;
    q4 = 4'd15;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ign_busy", 64'(busy4), 64'd1);
    tick();
    chk("ign_nodone", 64'(done4), 64'd0);
    tick();
    chk("ign_done", 64'(done4), 64'd1);
    chk("ign_p", 64'(p4), 64'h0F);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ign_no_second_done", 64'(done4), 64'd0);
      chk("ign_no_second_busy", 64'(busy4), 64'd0);
    end
    chk("ign_p_hold", 64'(p4), 64'h0F);

    // Asynchronous reset mid-RUN on WIDTH=8.
    m8 = 8'd12;
    q8 = 8'd13;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    chk("arst_busy_before", 64'(busy8), 64'd1);
    #1;
    n_rst8 = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_p", 64'(p8), 64'd0);
    #1;
    n_rst8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("arst_no_done", 64'(done8), 64'd0);
    end
    run8(8'd12, 8'd13, 16'h009C, "arst_fresh");
    tick();

    // start held through DONE: back-to-back runs, done every 5 cycles.
    m4 = 4'd2;
    q4 = 4'd3;
    start4 = 1'b1;
    tick();
    m4 = 4'd5;
    q4 = 4'd7;
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_a_done", 64'(done4), 64'd0);
      tick();
    end
    chk("b2b_a_done_e4", 64'(done4), 64'd1);
    chk("b2b_a_p", 64'(p4), 64'h06);
    tick();
    chk("b2b_reaccept_busy", 64'(busy4), 64'd1);
    chk("b2b_reaccept_done", 64'(done4), 64'd0);
    chk("b2b_p_held", 64'(p4), 64'h06);
    start4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b2b_b_done", 64'(done4), 64'(k == 4));
    end
    tick();
    chk("b2b_b_done_e9", 64'(done4), 64'd1);
    chk("b2b_b_p", 64'(p4), 64'h23);
    tick();
    chk("b2b_idle_done", 64'(done4), 64'd0);
    chk("b2b_idle_busy", 64'(busy4), 64'd0);

    run4(4'd9, 4'd1, 8'h09, "w4_one");
    tick();
    run4(4'd8, 4'd8, 8'h40, "w4_u8x8");
    tick();

`ifdef SHIFT_ADD_SIGNED_EN
    sgn4 = 1'b1;
    run4(4'h8, 4'h8, 8'h40, "s_min_min");
    tick();
    run4(4'd7, 4'hD, 8'hEB, "s_7_m3");
    tick();
    run4(4'hF, 4'd1, 8'hFF, "s_m1_1");
    tick();
    sgn4 = 1'b0;
    run4(4'h8, 4'h8, 8'h40, "s_off_8x8");
    tick();
    sgn8 = 1'b1;
    run8(8'h80, 8'h7F, 16'hC080, "s8_min_max");
    tick();
    sgn8 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
